// File: rtl/face_frame_streamer.sv
// Host-side driver for the face-detection core: streams one frame from the source RAM into
// the core pixel port, pulses enable_process, then captures the returned frame into the destination RAM.
module face_frame_streamer #(
  parameter int WIDTH       = 410,
  parameter int DEPTH       = 361,
  parameter int COLOR_DEPTH = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT     = 2**20,
  localparam int N  = WIDTH * DEPTH,
  localparam int AW = $clog2(N),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic                   src_rd_en_o,
  output logic [AW-1:0]          src_addr_o,
  input  logic [COLOR_DEPTH-1:0] src_data_i,
  output logic                   enable_o,
  output logic [COLOR_DEPTH-1:0] pixel_out_o,
  output logic                   enable_process_o,
  input  logic                   finish_i,
  input  logic [COLOR_DEPTH-1:0] image_in_i,
  output logic                   dst_we_o,
  output logic [AW-1:0]          dst_addr_o,
  output logic [COLOR_DEPTH-1:0] dst_data_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PREFETCH,
    S_ARM,
    S_STREAM,
    S_GAP,
    S_KICK,
    S_WAIT_FIN,
    S_SKIP,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [AW:0]   LAST_RD  = (AW+1)'(N - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [TW-1:0]          cnt_q, cnt_d;
  logic [COLOR_DEPTH-1:0] pix_q, pix_d;
  logic                   dstWe_q, dstWe_d;
  logic [AW-1:0]          dstAddr_q, dstAddr_d;
  logic [COLOR_DEPTH-1:0] dstData_q, dstData_d;

  // While pixel idx_q is on the core port, the read for pixel idx_q+2 is in flight.
  logic [AW:0] rdAddrWide;
  assign rdAddrWide = {1'b0, idx_q} + (AW+1)'(2);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      pix_q     <= '0;
      dstWe_q   <= 1'b0;
      dstAddr_q <= '0;
      dstData_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pix_q     <= pix_d;
      dstWe_q   <= dstWe_d;
      dstAddr_q <= dstAddr_d;
      dstData_q <= dstData_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    cnt_d            = cnt_q;
    pix_d            = pix_q;
    dstWe_d          = 1'b0;
    dstAddr_d        = dstAddr_q;
    dstData_d        = dstData_q;
    src_rd_en_o      = 1'b0;
    src_addr_o       = '0;
    enable_o         = 1'b0;
    enable_process_o = 1'b0;
    done_o           = 1'b0;
    error_o          = 1'b0;

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (start_i) state_d = S_PREFETCH;
      end
      S_PREFETCH: begin
        src_rd_en_o = 1'b1;
        state_d     = S_ARM;
      end
      S_ARM: begin
        enable_o = 1'b1;
        if (N > 1) begin
          src_rd_en_o = 1'b1;
          src_addr_o  = AW'(1);
        end
        pix_d   = src_data_i;
        idx_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (rdAddrWide <= LAST_RD) begin
          src_rd_en_o = 1'b1;
          src_addr_o  = rdAddrWide[AW-1:0];
        end
        if (idx_q == LAST_IDX) begin
          pix_d   = '0;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          pix_d = src_data_i;
          idx_d = idx_q + AW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_KICK;
        else                   cnt_d   = cnt_q + TW'(1);
      end
      S_KICK: begin
        enable_process_o = 1'b1;
        cnt_d            = '0;
        state_d          = S_WAIT_FIN;
      end
      S_WAIT_FIN: begin
        if (finish_i) begin
          state_d = S_SKIP;
        end else if (cnt_q == TO_LAST) begin
          error_o = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_SKIP: begin
        idx_d   = '0;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // The core must hold finish for the whole returned frame.
        if (!finish_i) begin
          error_o = 1'b1;
          state_d = S_IDLE;
        end else begin
          dstWe_d   = 1'b1;
          dstAddr_d = idx_q;
          dstData_d = image_in_i;
          if (idx_q == LAST_IDX) state_d = S_DONE;
          else                   idx_d   = idx_q + AW'(1);
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign pixel_out_o = pix_q;
  assign dst_we_o    = dstWe_q;
  assign dst_addr_o  = dstAddr_q;
  assign dst_data_o  = dstData_q;

endmodule
